store_tank: RTL and testbench

// - One mercury store tank: 16 long (36 p.i.) word slots on a recirculating serial delay line.
// - Far end of the main bus pair: captures mob from the Computer on stores (T, U orders).
// - Drives mib back to the Computer's Multiplicand/Multiplier loading on fetches.
// - Handles a single read or write request at a time.
// - Slot timing is locked to the digit pulse generator via d0.

---
 rtl/store_tank_pkg.sv | 43 ++++
 rtl/store_tank_if.sv | 38 +++
 rtl/store_tank_delay_line.sv | 36 +++
 rtl/store_tank.sv | 166 ++++++++++++++++
 tb/tb_store_tank.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/store_tank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_tank_pkg
// Description : Shared constants, FSM/op encodings and the window-decode
//               helper for the mercury store tank. The p.i. constants are the
//               same ones the digit pulse generator uses.
// Revision    : 1.0  initial release
// ============================================================================
package store_tank_pkg;

    localparam int ST_WORDS   = 16;             // long-word slots per tank
    localparam int ST_WORD_PI = 36;             // p.i. per long word / minor cycle
    localparam int ST_AW      = 4;              // log2(ST_WORDS)
    localparam int ST_HALF_PI = ST_WORD_PI / 2; // p.i. per short word

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // True when p.i. 'pi' belongs to the part of the word being transferred:
    // the whole word for a long transfer, otherwise the addressed half.
    function automatic logic pi_in_window(input logic is_short,
                                          input logic half,
                                          input int   pi,
                                          input int   half_pi);
        if (!is_short)
            return 1'b1;
        else if (half)
            return (pi >= half_pi);
        else
            return (pi < half_pi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_tank_if.sv
`default_nettype none
// ============================================================================
// Module      : store_tank_if
// Description : Main bus pair between the Computer and one store tank.
//   addr    [AW:1] slot, [0] half      f1_neg  1 = short (half word) transfer
//   rd_req  fetch request              wr_req  store request
//   mob     serial data to the tank    mib     serial data to the Computer
//   busy    request in progress        done    one-cycle completion pulse
//   master  = Computer side, slave = store tank side
// Revision    : 1.0  initial release
// ============================================================================
interface store_tank_if
    import store_tank_pkg::*;
#(
    parameter int AW = ST_AW
) ();

    logic [AW:0] addr;
    logic        f1_neg;
    logic        rd_req;
    logic        wr_req;
    logic        mob;
    logic        mib;
    logic        busy;
    logic        done;

    modport master (
        output addr, f1_neg, rd_req, wr_req, mob,
        input  mib, busy, done
    );

    modport slave (
        input  addr, f1_neg, rd_req, wr_req, mob,
        output mib, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/store_tank_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : delay_line
// Description : LEN-bit recirculating serial delay line (the mercury column).
//   clk     system clock, one p.i. per cycle
//   rst_n   asynchronous active-low clear of the whole line
//   en_i    shift enable (held low until the tank is synchronised)
//   head_i  bit entering the line
//   tail_o  bit leaving the line, exactly LEN enabled cycles after entry
// Revision    : 1.0  initial release
// ============================================================================
module delay_line
    import store_tank_pkg::*;
#(
    parameter int LEN = ST_WORDS * ST_WORD_PI
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en_i,
    input  wire logic head_i,
    output logic      tail_o
);

    logic [LEN-1:0] line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            line_q <= '0;
        else if (en_i)
            line_q <= {line_q[LEN-2:0], head_i};
    end

    assign tail_o = line_q[LEN-1];

endmodule
`default_nettype wire

// File: rtl/store_tank.sv
`default_nettype none
// ============================================================================
// Module      : store_tank
// Description : One mercury store tank of WORDS long words on a recirculating
//               delay line. Serves one fetch or store at a time over the main
//               bus pair, with slot timing locked to the digit pulse d0.
//   clk     system clock, one p.i. per cycle
//   rst_n   asynchronous active-low reset (also clears the line)
//   d0      digit pulse, high in the last p.i. before p.i. 0
//   bus     store_tank_if.slave: addr/f1_neg/rd_req/wr_req/mob in,
//           mib/busy/done out
//   d0_err  sticky flag: d0 arrived when pi_cnt was not WORD_PI-1
// Revision    : 1.0  initial release
// ============================================================================
module store_tank
    import store_tank_pkg::*;
#(
    parameter int WORDS   = ST_WORDS,
    parameter int WORD_PI = ST_WORD_PI,
    parameter int AW      = ST_AW
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   d0,
    store_tank_if.slave bus,
    output logic        d0_err
);

    localparam int            PW        = (WORD_PI > 1) ? $clog2(WORD_PI) : 1;
    localparam int            LEN       = WORDS * WORD_PI;
    localparam logic [PW-1:0] PI_LAST   = PW'(WORD_PI - 1);
    localparam logic [AW-1:0] SLOT_LAST = AW'(WORDS - 1);

    // Timing
    logic [PW-1:0] pi_q,   pi_d;
    logic [AW-1:0] slot_q, slot_d;
    logic          d0_err_q, d0_err_d;
    logic          synced_q;

    // Request / FSM
    state_t        state_q;
    op_t           op_q;
    logic [AW:0]   addr_q;
    logic          short_q;
    logic          busy_q;
    logic          done_q;

    // Datapath
    logic          w_window;
    logic          w_head;
    logic          w_tail;

    // ------------------------------------------------------------------
    // Counter next-state. An aligned d0 coincides with the natural wrap,
    // so it advances the slot; a misaligned d0 only realigns the p.i.
    // count and flags the error. The first d0 just starts the counters.
    // ------------------------------------------------------------------
    always_comb begin
        pi_d     = pi_q;
        slot_d   = slot_q;
        d0_err_d = d0_err_q;
        if (d0) begin
            pi_d = '0;
            if (synced_q) begin
                if (pi_q == PI_LAST)
                    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
                else
                    d0_err_d = 1'b1;
            end
        end else if (synced_q) begin
            if (pi_q == PI_LAST) begin
                pi_d   = '0;
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end else begin
                pi_d = pi_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_q     <= '0;
            slot_q   <= '0;
            d0_err_q <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            pi_q     <= pi_d;
            slot_q   <= slot_d;
            d0_err_q <= d0_err_d;
            if (d0)
                synced_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM. WAIT looks at the counters' next values so that XFER
    // is entered exactly on p.i. 0 of the addressed slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            short_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (synced_q && (bus.wr_req || bus.rd_req)) begin
                        addr_q  <= bus.addr;
                        short_q <= bus.f1_neg;
                        op_q    <= bus.wr_req ? OP_WRITE : OP_READ;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if ((pi_d == '0) && (slot_d == addr_q[AW:1]))
                        state_q <= S_XFER;
                end
                S_XFER: begin
                    if (pi_q == PI_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window decode and write/recirculate mux
    // ------------------------------------------------------------------
    assign w_window = (state_q == S_XFER)
                   && (slot_q == addr_q[AW:1])
                   && pi_in_window(short_q, addr_q[0], int'(pi_q), WORD_PI / 2);

    assign w_head = (w_window && (op_q == OP_WRITE)) ? bus.mob : w_tail;

    delay_line #(
        .LEN (LEN)
    ) u_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (synced_q),
        .head_i (w_head),
        .tail_o (w_tail)
    );

    // Fetch data leaves the tail combinationally, in the same p.i.
    assign bus.mib  = w_window && (op_q == OP_READ) && w_tail;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign d0_err   = d0_err_q;

endmodule
`default_nettype wire

// File: tb/tb_store_tank.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_tank
// Description : Self-checking bench for store_tank. A reference model keeps
//               the tank contents as a flat bit array addressed by absolute
//               line phase, plus the current (slot, p.i.) position as a
//               single number modulo the line length.
// Revision    : 1.0  initial release
// ============================================================================
module tb_store_tank;
    import store_tank_pkg::*;

    localparam int WORDS   = ST_WORDS;
    localparam int WORD_PI = ST_WORD_PI;
    localparam int AW      = ST_AW;
    localparam int LEN     = WORDS * WORD_PI;
    localparam int HALF    = WORD_PI / 2;

    logic clk = 1'b0;
    logic rst_n;
    logic d0;
    logic d0_err;

    store_tank_if #(.AW(AW)) bus ();

    store_tank #(
        .WORDS   (WORDS),
        .WORD_PI (WORD_PI),
        .AW      (AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d0     (d0),
        .bus    (bus),
        .d0_err (d0_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model
    bit line_m [LEN];
    int m_pos;      // slot*WORD_PI + p.i. of the current cycle
    int m_off;      // physical line phase minus logical position
    bit m_synced;
    bit d0_req;     // extra d0 to inject in the next step

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (line_m[i]) line_m[i] = 1'b0;
        m_pos    = 0;
        m_off    = 0;
        m_synced = 1'b0;
    endtask

    function automatic bit lbit(input int slot, input int k);
        return line_m[(slot * WORD_PI + k + m_off) % LEN];
    endfunction

    // One clock: drive d0, pass the edge, update the model, settle at negedge.
    task automatic step();
        int pi;
        pi     = m_pos % WORD_PI;
        d0     = d0_req || (m_synced && (pi == WORD_PI - 1));
        d0_req = 1'b0;
        @(posedge clk);
        if (d0) begin
            if (!m_synced) begin
                m_synced = 1'b1;
                m_pos    = 0;
            end else if (pi == WORD_PI - 1) begin
                m_pos = (m_pos + 1) % LEN;
            end else begin
                // The line keeps moving while the counters jump back to p.i. 0.
                m_off = (m_off + pi + 1) % LEN;
                m_pos = m_pos - pi;
            end
        end else if (m_synced) begin
            m_pos = (m_pos + 1) % LEN;
        end
        @(negedge clk);
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; (i <= LEN) && (m_pos != target); i++) step();
    endtask

    // Issue one request in IDLE and follow it to the cycle after done.
    task automatic do_xfer(input bit wr, input bit rd, input int slot, input bit half,
                           input bit shortx, input logic [35:0] data, input bit extra,
                           input string tag, output logic [35:0] cap, output int done_at);
        int p, tmp, lat, k, dones, busy_bad, mib_bad;
        bit win;
        logic [35:0] expw;
        p   = m_pos;
        tmp = slot * WORD_PI - p - 2;
        tmp = ((tmp % LEN) + LEN) % LEN;
        lat = tmp + 2;               // accept cycle -> first XFER p.i.
        expw = '0;
        cap  = '0;
        for (int j = 0; j < WORD_PI; j++)
            if (!shortx || (half ? (j >= HALF) : (j < HALF)))
                expw[j] = lbit(slot, j);
        dones = 0; busy_bad = 0; mib_bad = 0; done_at = -1;
        bus.addr   = {AW'(slot), half};
        bus.f1_neg = shortx;
        bus.wr_req = wr;
        bus.rd_req = rd;
        bus.mob    = 1'($urandom);
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        for (int c = 1; c <= lat + WORD_PI + 1; c++) begin
            k   = c - lat;
            win = (k >= 0) && (k < WORD_PI) && (!shortx || (half ? (k >= HALF) : (k < HALF)));
            if (bus.done === 1'b1) begin dones++; done_at = c; end
            if (bus.busy !== (c < lat + WORD_PI)) busy_bad++;
            if (win && !wr) cap[k] = bus.mib;
            else if (bus.mib !== 1'b0) mib_bad++;
            bus.mob = (win && wr) ? data[k] : 1'($urandom);
            if (extra && (c == 3)) begin
                bus.wr_req = 1'b1;
                bus.addr   = (AW+1)'($urandom);
            end else begin
                bus.wr_req = 1'b0;
            end
            step();
        end
        if (wr) begin
            for (int j = 0; j < WORD_PI; j++)
                if (!shortx || (half ? (j >= HALF) : (j < HALF)))
                    line_m[(slot * WORD_PI + j + m_off) % LEN] = data[j];
        end else begin
            chk({tag, "_data"}, 64'(cap), 64'(expw));
        end
        chk({tag, "_busy_errs"}, 64'(busy_bad), 64'd0);
        chk({tag, "_mib_stray"}, 64'(mib_bad), 64'd0);
        chk({tag, "_done_count"}, 64'(dones), 64'd1);
        chk({tag, "_done_cycle"}, 64'(done_at), 64'(lat + WORD_PI));
    endtask

    initial begin
        logic [35:0] cap, prev;
        logic [63:0] rnd;
        int          done_at, lat;
        bit          wr, sh, hf;
        int          slot;

        rst_n = 1'b0; d0 = 1'b0; d0_req = 1'b0;
        bus.addr = '0; bus.f1_neg = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.mob = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_mib", 64'(bus.mib), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_d0_err", 64'(d0_err), 64'd0);
        rst_n = 1'b1;

        // Requests before the first d0 are ignored.
        bus.rd_req = 1'b1; bus.addr = {4'd3, 1'b0};
        repeat (5) step();
        chk("presync_busy", 64'(bus.busy), 64'd0);
        bus.rd_req = 1'b0;
        d0_req = 1'b1;
        step();

        // Fresh tank reads zero.
        do_xfer(0, 1, 3, 0, 0, '0, 0, "rd3", cap, done_at);
        chk("rd3_zero", 64'(cap), 64'd0);

        do_xfer(1, 0, 5, 0, 0, 36'h9_0000_0005, 0, "wr5", cap, done_at);
        do_xfer(0, 1, 5, 0, 0, '0, 0, "rd5", cap, done_at);
        chk("rd5_value", 64'(cap), 64'h9_0000_0005);

        // Short write to the upper half leaves the lower half alone.
        rnd  = {$urandom, $urandom};
        prev = rnd[35:0];
        do_xfer(1, 0, 7, 0, 0, prev, 0, "wr7_full", cap, done_at);
        do_xfer(1, 0, 7, 1, 1, {18'h2AAAA, 18'h0}, 0, "wr7_short", cap, done_at);
        do_xfer(0, 1, 7, 0, 0, '0, 0, "rd7", cap, done_at);
        chk("rd7_value", 64'(cap), 64'({18'h2AAAA, prev[17:0]}));

        // Both requests together: write wins; a request while busy is ignored.
        do_xfer(1, 1, 9, 0, 0, 36'hA_5A5A_5A5A, 1, "wr9_both", cap, done_at);
        do_xfer(0, 1, 9, 0, 0, '0, 0, "rd9", cap, done_at);
        chk("rd9_value", 64'(cap), 64'hA_5A5A_5A5A);

        // Slot 15 requested at slot 15 p.i. 1: one full revolution less one.
        wait_pos(15 * WORD_PI + 1);
        do_xfer(0, 1, 15, 0, 0, '0, 0, "rd15", cap, done_at);
        chk("slot15_latency", 64'(done_at), 64'(575 + WORD_PI));

        // Randomised transactions, each write followed by a full read-back.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 40)) step();
            wr   = 1'($urandom);
            slot = int'($urandom_range(0, WORDS - 1));
            sh   = 1'($urandom);
            hf   = 1'($urandom);
            rnd  = {$urandom, $urandom};
            do_xfer(wr, !wr, slot, hf, sh, rnd[35:0], 0, "rand", cap, done_at);
            if (wr) do_xfer(0, 1, slot, 0, 0, '0, 0, "rand_rb", cap, done_at);
        end

        // Skewed d0 at p.i. 20.
        for (int i = 0; (i < WORD_PI) && ((m_pos % WORD_PI) != 20); i++) step();
        d0_req = 1'b1;
        step();
        chk("skew_d0_err", 64'(d0_err), 64'd1);
        repeat (80) step();
        chk("skew_d0_err_sticky", 64'(d0_err), 64'd1);
        do_xfer(0, 1, 7, 0, 0, '0, 0, "skew_rd7", cap, done_at);
        do_xfer(1, 0, 5, 0, 0, 36'h9_0000_0005, 0, "skew_wr5", cap, done_at);
        do_xfer(0, 1, 5, 0, 0, '0, 0, "skew_rd5", cap, done_at);
        chk("skew_rd5_value", 64'(cap), 64'h9_0000_0005);

        // Asynchronous reset in the middle of a fetch of slot 5.
        lat = (((5 * WORD_PI - m_pos - 2) % LEN) + LEN) % LEN + 2;
        bus.addr = {4'd5, 1'b0}; bus.f1_neg = 1'b0; bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        repeat (lat - 1) step();
        chk("rst_pre_mib", 64'(bus.mib), 64'd1);
        chk("rst_pre_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mib", 64'(bus.mib), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_d0_err", 64'(d0_err), 64'd0);
        model_reset();
        d0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("rst_after_done", 64'(bus.done), 64'd0);
        d0_req = 1'b1;
        step();
        do_xfer(0, 1, 5, 0, 0, '0, 0, "rst_rd5", cap, done_at);
        chk("rst_rd5_zero", 64'(cap), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
